lcd_bus_sequencer: RTL

Owns the single SPI LCD pin set (MOSI, DC, CS) and shares it between the panel engines. After reset it waits a power-up delay, runs the init engine, then the screen-clear engine, then serves two drawing requesters with round-robin arbitration. Each engine keeps its own start/done handshake and drives its own mosi/dc/cs; this block selects which one reaches the pins and enforces a CS-high gap between owners.

---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_rr_arb2.sv | 27 ++
 rtl/lcd_bus_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus sequencer: FSM states, pin-owner
// encoding and the pin levels driven while nobody owns the bus.
package lcd_pkg;

  typedef enum logic [3:0] {
    StWaitPwr,
    StInitGo,
    StInitRun,
    StGap1,
    StClrGo,
    StClrRun,
    StGap2,
    StIdle,
    StReqGo,
    StReqRun,
    StGap3
  } state_e;

  typedef enum logic [2:0] {
    OwnNone,
    OwnInit,
    OwnClr,
    OwnReq0,
    OwnReq1
  } owner_e;

  localparam logic IdleMosi = 1'b0;
  localparam logic IdleDc   = 1'b0;
  localparam logic IdleCs   = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin picker. The pointer holds the last requester served; on a
// tie the other one wins, and after reset the pointer favours requester 0.
module lcd_rr_arb2
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       any,
  output logic       sel
);

  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= sel;
    end
  end

  assign any = |req;
  assign sel = (req == 2'b11) ? ~last_q : req[1];

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Shares the SPI LCD pins between init, clear and two drawing requesters, with a
// CS-high gap between owners. Define LCD_SEQ_TIMEOUT_EN for per-job timeouts.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned DELAY   = 20,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_init_start,
  output logic       o_clr_start,
  input  logic       i_init_done,
  input  logic       i_clr_done,
  input  logic       i_init_mosi,
  input  logic       i_init_dc,
  input  logic       i_init_cs,
  input  logic       i_clr_mosi,
  input  logic       i_clr_dc,
  input  logic       i_clr_cs,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic [1:0] o_req_start,
  input  logic [1:0] i_req_done,
  input  logic [1:0] i_req_mosi,
  input  logic [1:0] i_req_dc,
  input  logic [1:0] i_req_cs,
  output logic       o_mosi,
  output logic       o_dc,
  output logic       o_cs,
  output logic       o_ready,
  output logic       o_err
);

  localparam int unsigned CntW = $clog2(max3(DELAY, GAP, TIMEOUT) + 1);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_q, sel_d;
  logic            arb_any, arb_sel, arb_upd;
  logic            in_run, cur_done, run_done, tmo, job_end, gap_end;

  lcd_rr_arb2 u_arb (
    .clk (i_clk),
    .rst (i_rst),
    .req (i_req),
    .upd (arb_upd),
    .any (arb_any),
    .sel (arb_sel)
  );

  assign in_run = state_q inside {StInitRun, StClrRun, StReqRun};

  always_comb begin
    case (state_q)
      StInitRun: cur_done = i_init_done;
      StClrRun:  cur_done = i_clr_done;
      StReqRun:  cur_done = i_req_done[sel_q];
      default:   cur_done = 1'b0;
    endcase
  end

  // cnt is zero in the first RUN cycle, so a done level left over from start is ignored.
  assign run_done = cur_done && (cnt_q != '0);
`ifdef LCD_SEQ_TIMEOUT_EN
  assign tmo = in_run && !run_done && (cnt_q == CntW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif
  assign job_end = run_done || tmo;
  assign gap_end = (cnt_q == CntW'(GAP - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    arb_upd = 1'b0;
    case (state_q)
      StWaitPwr: if (cnt_q == CntW'(DELAY)) state_d = StInitGo;
      StInitGo:  state_d = StInitRun;
      StInitRun: if (job_end) state_d = StGap1;
      StGap1:    if (gap_end) state_d = StClrGo;
      StClrGo:   state_d = StClrRun;
      StClrRun:  if (job_end) state_d = StGap2;
      StGap2:    if (gap_end) state_d = StIdle;
      StIdle: begin
        if (arb_any) begin
          state_d = StReqGo;
          sel_d   = arb_sel;
          arb_upd = 1'b1;
        end
      end
      StReqGo:   state_d = StReqRun;
      StReqRun:  if (job_end) state_d = StGap3;
      StGap3:    if (gap_end) state_d = StIdle;
      default:   state_d = StWaitPwr;
    endcase
  end

  // One counter serves power-up wait, gaps and (optionally) job timeouts.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_run) begin
`ifdef LCD_SEQ_TIMEOUT_EN
      cnt_d = cnt_q + CntW'(1);
`else
      cnt_d = CntW'(1);
`endif
    end else if (state_q != StIdle) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    case (state_d)
      StInitGo, StInitRun: owner_d = OwnInit;
      StClrGo, StClrRun:   owner_d = OwnClr;
      StReqGo, StReqRun:   owner_d = sel_d ? OwnReq1 : OwnReq0;
      default:             owner_d = OwnNone;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StWaitPwr;
      owner_q <= OwnNone;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

`ifdef LCD_SEQ_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (tmo) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  always_comb begin
    o_mosi = IdleMosi;
    o_dc   = IdleDc;
    o_cs   = IdleCs;
    o_gnt  = 2'b00;
    case (owner_q)
      OwnInit: begin
        o_mosi = i_init_mosi;
        o_dc   = i_init_dc;
        o_cs   = i_init_cs;
      end
      OwnClr: begin
        o_mosi = i_clr_mosi;
        o_dc   = i_clr_dc;
        o_cs   = i_clr_cs;
      end
      OwnReq0: begin
        o_mosi = i_req_mosi[0];
        o_dc   = i_req_dc[0];
        o_cs   = i_req_cs[0];
        o_gnt  = 2'b01;
      end
      OwnReq1: begin
        o_mosi = i_req_mosi[1];
        o_dc   = i_req_dc[1];
        o_cs   = i_req_cs[1];
        o_gnt  = 2'b10;
      end
      default: ;
    endcase
  end

  assign o_init_start = (state_q == StInitGo);
  assign o_clr_start  = (state_q == StClrGo);
  assign o_req_start  = (state_q == StReqGo) ? {sel_q, ~sel_q} : 2'b00;
  assign o_ready      = (state_q == StIdle);

endmodule
